// File: rtl/ahb_mtx_input_hold_stage.sv
// Per-master input stage of the AHB bus matrix.
// Presents the master's address phase to the target decoder/arbiter, parks it
// in a one-deep hold register when this port is not granted, and tracks the
// data phase so that ready/response can be returned to the master.
module ahb_mtx_input_hold_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic [ADDR_W-1:0] HADDRI,
  output logic [1:0]        HTRANSI,
  output logic              HWRITEI,
  output logic [2:0]        HSIZEI,
  output logic [2:0]        HBURSTI,
  output logic [3:0]        HPROTI,
  output logic              HMASTLOCKI,
  output logic              trans_req,
  input  logic              addr_granted,
  input  logic              HREADYM,
  input  logic              HRESPM
);

  logic              live_valid;
  logic              accept;
  logic              capture;

  logic              pend_q,       pend_d;
  logic              data_act_q,   data_act_d;
  logic [ADDR_W-1:0] addr_hold_q,  addr_hold_d;
  logic [1:0]        trans_hold_q, trans_hold_d;
  logic              write_hold_q, write_hold_d;
  logic [2:0]        size_hold_q,  size_hold_d;
  logic [2:0]        burst_hold_q, burst_hold_d;
  logic [3:0]        prot_hold_q,  prot_hold_d;
  logic              lock_hold_q,  lock_hold_d;

  // Qualify the master's address phase and this cycle's acceptance by the target.
  always_comb begin
    live_valid = HSELS & HREADYS & HTRANSS[1];
    accept     = addr_granted & HREADYM;
    capture    = live_valid & ~accept;
  end

  // Address mux: the held transfer always wins, even if the master has deselected,
  // since it was already accepted from the master.
  always_comb begin
    if (pend_q) begin
      HADDRI     = addr_hold_q;
      HTRANSI    = trans_hold_q;
      HWRITEI    = write_hold_q;
      HSIZEI     = size_hold_q;
      HBURSTI    = burst_hold_q;
      HPROTI     = prot_hold_q;
      HMASTLOCKI = lock_hold_q;
    end else begin
      HADDRI     = HADDRS;
      HTRANSI    = HSELS ? HTRANSS : 2'b00;
      HWRITEI    = HWRITES;
      HSIZEI     = HSIZES;
      HBURSTI    = HBURSTS;
      HPROTI     = HPROTS;
      HMASTLOCKI = HMASTLOCKS;
    end
    trans_req = pend_q | live_valid;
  end

  // Master-facing response: stall while a transfer is parked, otherwise mirror
  // the target only while this port owns a data phase.
  always_comb begin
    if (pend_q)          HREADYOUTS = 1'b0;
    else if (data_act_q) HREADYOUTS = HREADYM;
    else                 HREADYOUTS = 1'b1;
    HRESPS = data_act_q ? HRESPM : 1'b0;
  end

  // Next-state for the pending flag, data-phase flag and hold registers.
  // Held values are left in place on release; pend_q alone decides their use.
  always_comb begin
    pend_d       = pend_q;
    data_act_d   = data_act_q;
    addr_hold_d  = addr_hold_q;
    trans_hold_d = trans_hold_q;
    write_hold_d = write_hold_q;
    size_hold_d  = size_hold_q;
    burst_hold_d = burst_hold_q;
    prot_hold_d  = prot_hold_q;
    lock_hold_d  = lock_hold_q;

    if (pend_q && accept) begin
      pend_d = 1'b0;
    end else if (capture) begin
      pend_d       = 1'b1;
      addr_hold_d  = HADDRS;
      trans_hold_d = HTRANSS;
      write_hold_d = HWRITES;
      size_hold_d  = HSIZES;
      burst_hold_d = HBURSTS;
      prot_hold_d  = HPROTS;
      lock_hold_d  = HMASTLOCKS;
    end

    // A new accepted transfer takes priority over a completing data phase,
    // so back-to-back pipelined transfers keep data_act high.
    if (accept && HTRANSI[1])
      data_act_d = 1'b1;
    else if (HREADYM && data_act_q)
      data_act_d = 1'b0;
  end

  // State registers with synchronous reset; any held transfer is dropped.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q       <= 1'b0;
      data_act_q   <= 1'b0;
      addr_hold_q  <= '0;
      trans_hold_q <= 2'b00;
      write_hold_q <= 1'b0;
      size_hold_q  <= 3'b000;
      burst_hold_q <= 3'b000;
      prot_hold_q  <= 4'b0000;
      lock_hold_q  <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      data_act_q   <= data_act_d;
      addr_hold_q  <= addr_hold_d;
      trans_hold_q <= trans_hold_d;
      write_hold_q <= write_hold_d;
      size_hold_q  <= size_hold_d;
      burst_hold_q <= burst_hold_d;
      prot_hold_q  <= prot_hold_d;
      lock_hold_q  <= lock_hold_d;
    end
  end

  // The master is stalled while a transfer is parked, so it can never present
  // a second live transfer on top of it; that is what makes one slot enough.
  hold_depth_one: assert property (@(posedge HCLK) disable iff (HRESET) !(live_valid && pend_q));

endmodule

// File: tb/tb_ahb_mtx_input_hold_stage.sv
// Directed bench for ahb_mtx_input_hold_stage.
module tb_ahb_mtx_input_hold_stage;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic [31:0] HADDRI;
  logic [1:0]  HTRANSI;
  logic        HWRITEI;
  logic [2:0]  HSIZEI;
  logic [2:0]  HBURSTI;
  logic [3:0]  HPROTI;
  logic        HMASTLOCKI;
  logic        trans_req;
  logic        addr_granted;
  logic        HREADYM;
  logic        HRESPM;

  // The master normally sees its own ready; hready_loop=0 lets the bench force it.
  logic        hready_loop;
  logic        hreadys_force;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 HCLK = ~HCLK;

  assign HREADYS = hready_loop ? HREADYOUTS : hreadys_force;

  ahb_mtx_input_hold_stage #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HADDRI(HADDRI), .HTRANSI(HTRANSI),
    .HWRITEI(HWRITEI), .HSIZEI(HSIZEI), .HBURSTI(HBURSTI), .HPROTI(HPROTI),
    .HMASTLOCKI(HMASTLOCKI), .trans_req(trans_req), .addr_granted(addr_granted),
    .HREADYM(HREADYM), .HRESPM(HRESPM)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven there.
  task automatic next_cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic master(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] burst);
    HSELS   = sel;
    HADDRS  = addr;
    HTRANSS = trans;
    HWRITES = wr;
    HBURSTS = burst;
  endtask

  initial begin
    HRESET = 1'b1; HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
    addr_granted = 1'b0; HREADYM = 1'b1; HRESPM = 1'b0;
    hready_loop = 1'b1; hreadys_force = 1'b1;

    // Reset
    repeat (2) @(posedge HCLK);
    #1; HRESET = 1'b0; settle();
    check_eq("rst_readyout", HREADYOUTS, 1);
    check_eq("rst_resp",     HRESPS, 0);
    check_eq("rst_req",      trans_req, 0);
    check_eq("rst_trans",    HTRANSI, 0);

    // Granted NONSEQ write: combinational pass-through
    next_cyc();
    master(1, 32'h2000_0010, 2'b10, 1, 3'd0);
    addr_granted = 1; HREADYM = 1; settle();
    check_eq("pt_addr",  HADDRI, 32'h2000_0010);
    check_eq("pt_trans", HTRANSI, 2'b10);
    check_eq("pt_write", HWRITEI, 1);
    check_eq("pt_req",   trans_req, 1);
    next_cyc();
    master(0, 32'h0, 2'b00, 0, 3'd0);
    HREADYM = 0; settle();
    check_eq("pt_nocapture", dut.pend_q, 0);
    check_eq("pt_data_act",  dut.data_act_q, 1);
    check_eq("pt_ready_wait", HREADYOUTS, 0);
    HREADYM = 1; settle();
    check_eq("pt_ready_done", HREADYOUTS, 1);
    next_cyc(); settle();
    check_eq("pt_data_idle", dut.data_act_q, 0);

    // Ungranted NONSEQ read: captured, held for 3 cycles, then issued
    master(1, 32'h2000_0040, 2'b10, 0, 3'd0);
    addr_granted = 0; HREADYM = 1; settle();
    check_eq("hold_req_live", trans_req, 1);
    next_cyc();
    master(1, 32'hDEAD_BEEF, 2'b10, 1, 3'd0); settle();
    check_eq("hold_pend",  dut.pend_q, 1);
    check_eq("hold_ready", HREADYOUTS, 0);
    check_eq("hold_req",   trans_req, 1);
    check_eq("hold_addr",  HADDRI, 32'h2000_0040);
    check_eq("hold_write", HWRITEI, 0);
    next_cyc();
    master(0, 32'hDEAD_BEEF, 2'b00, 1, 3'd0); settle();
    check_eq("hold_desel_trans", HTRANSI, 2'b10);
    check_eq("hold_desel_addr",  HADDRI, 32'h2000_0040);
    check_eq("hold_desel_req",   trans_req, 1);
    next_cyc();
    addr_granted = 1; settle();
    check_eq("hold_issue_addr", HADDRI, 32'h2000_0040);
    next_cyc(); settle();
    check_eq("hold_released", dut.pend_q, 0);
    check_eq("hold_data_act", dut.data_act_q, 1);
    check_eq("hold_data_rdy", HREADYOUTS, 1);
    check_eq("hold_idle_trans", HTRANSI, 2'b00);
    next_cyc(); settle();
    check_eq("hold_data_done", dut.data_act_q, 0);

    // INCR4 burst, target waits two cycles on beat 2's data phase
    addr_granted = 1; HREADYM = 1;
    master(1, 32'h0000_0100, 2'b10, 1, 3'd3); settle();
    check_eq("b1_req", trans_req, 1);
    next_cyc();
    master(1, 32'h0000_0104, 2'b11, 1, 3'd3); settle();
    check_eq("b2_ready", HREADYOUTS, 1);
    check_eq("b2_addr",  HADDRI, 32'h0000_0104);
    next_cyc();
    master(1, 32'h0000_0108, 2'b11, 1, 3'd3); HREADYM = 0; settle();
    check_eq("b3_wait1_ready", HREADYOUTS, 0);
    check_eq("b3_wait1_req",   trans_req, 0);
    next_cyc(); settle();
    check_eq("b3_wait2_ready", HREADYOUTS, 0);
    check_eq("b3_wait2_pend",  dut.pend_q, 0);
    check_eq("b3_wait2_act",   dut.data_act_q, 1);
    next_cyc(); HREADYM = 1; settle();
    check_eq("b3_go_ready", HREADYOUTS, 1);
    check_eq("b3_go_req",   trans_req, 1);
    next_cyc();
    master(1, 32'h0000_010C, 2'b11, 1, 3'd3); settle();
    check_eq("b4_pend", dut.pend_q, 0);
    check_eq("b4_burst", HBURSTI, 3'd3);
    next_cyc();
    master(1, 32'h0000_0110, 2'b00, 0, 3'd0); settle();
    check_eq("b4_data_act", dut.data_act_q, 1);
    check_eq("b4_idle_req", trans_req, 0);
    next_cyc(); settle();
    check_eq("burst_done", dut.data_act_q, 0);
    check_eq("burst_pend", dut.pend_q, 0);

    // Target ERROR response
    master(1, 32'h3000_0000, 2'b10, 0, 3'd0); settle();
    next_cyc();
    master(0, 32'h0, 2'b00, 0, 3'd0);
    HREADYM = 0; HRESPM = 1; settle();
    check_eq("err1_resp",  HRESPS, 1);
    check_eq("err1_ready", HREADYOUTS, 0);
    next_cyc();
    HREADYM = 1; HRESPM = 1; settle();
    check_eq("err2_resp",  HRESPS, 1);
    check_eq("err2_ready", HREADYOUTS, 1);
    next_cyc();
    HRESPM = 1; settle();
    check_eq("err_after_resp", HRESPS, 0);
    HRESPM = 0;

    // Reset with a held transfer and an open data phase
    master(1, 32'h4000_0000, 2'b10, 1, 3'd0); addr_granted = 1; HREADYM = 1; settle();
    next_cyc();
    hready_loop = 0; hreadys_force = 1;
    master(1, 32'h4000_0004, 2'b10, 1, 3'd0); addr_granted = 0; HREADYM = 0; settle();
    next_cyc();
    master(0, 32'h0, 2'b00, 0, 3'd0); hreadys_force = 0; settle();
    check_eq("pre_rst_pend", dut.pend_q, 1);
    check_eq("pre_rst_act",  dut.data_act_q, 1);
    check_eq("pre_rst_held", HADDRI, 32'h4000_0004);
    HRESET = 1;
    next_cyc();
    HRESET = 0; hready_loop = 1; settle();
    check_eq("mid_rst_pend",  dut.pend_q, 0);
    check_eq("mid_rst_act",   dut.data_act_q, 0);
    check_eq("mid_rst_ready", HREADYOUTS, 1);
    check_eq("mid_rst_req",   trans_req, 0);
    check_eq("mid_rst_trans", HTRANSI, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_input_hold_stage.md
Name: ahb_mtx_input_hold_stage

Overview:
- Per-master input stage of the bus matrix, directly upstream of each per-target round-robin arbiter.
- Accepts the master's address phase and holds it in a one-deep register when the target arbiter has not granted this port.
- Presents the live or held transfer to the target's decoder/arbiter as a request, then tracks the data phase and returns HREADYOUTS/HRESPS to the master.

Parameters:
- ADDR_W, 32, address width.

Ports:
- HCLK  in  1  AHB clock.
- HRESET  in  1  synchronous reset, active-high.
- HSELS  in  1  master-side select.
- HADDRS  in  ADDR_W  master address.
- HTRANSS  in  2  master transfer type.
- HWRITES  in  1  master write.
- HSIZES  in  3  master size.
- HBURSTS  in  3  master burst.
- HPROTS  in  4  master protection.
- HMASTLOCKS  in  1  master lock.
- HREADYS  in  1  master-side bus ready (previous data phase done).
- HREADYOUTS  out  1  ready returned to master.
- HRESPS  out  1  response returned to master (0 OKAY, 1 ERROR).
- HADDRI  out  ADDR_W  address to decoder/arbiter/output stage.
- HTRANSI  out  2  transfer type to decoder/arbiter/output stage.
- HWRITEI  out  1  write to output stage.
- HSIZEI  out  3  size to output stage.
- HBURSTI  out  3  burst to output stage.
- HPROTI  out  4  protection to output stage.
- HMASTLOCKI  out  1  lock to output stage.
- trans_req  out  1  request; the decoder qualifies it per target into req_portN.
- addr_granted  in  1  this port is the selected addr_in_port at its decoded target (no_port low).
- HREADYM  in  1  target HREADY (address accept / data complete).
- HRESPM  in  1  target response for this port's data phase.

Behaviour:
- Reset (HRESET high at posedge): pend=0, data_act=0, all hold registers 0. Outputs then show HREADYOUTS=1, HRESPS=0, trans_req=0 and HTRANSI=IDLE (if HSELS=0).
- Live transfer: live_valid = HSELS & HREADYS & HTRANSS[1].
- Address mux: pend=1 drives HADDRI..HMASTLOCKI from hold registers. pend=0 drives them from master inputs, with HTRANSI = HSELS ? HTRANSS : 2'b00.
- trans_req = pend | live_valid. BUSY and IDLE do not request, but HMASTLOCKI still follows.
- accept = addr_granted & HREADYM, evaluated the same cycle.
- Capture: live_valid & ~accept loads all address-phase signals into hold registers at posedge, and pend becomes 1.
- Release: pend & accept clears pend at posedge. Held values stay in the registers; they are ignored.
- data_act is set at posedge when accept & HTRANSI[1], and cleared when ~(accept & HTRANSI[1]) & HREADYM & data_act.
- Pipelined overlap: a completing data phase plus a new accepted transfer in the same cycle keeps data_act=1.
- HREADYOUTS: 0 if pend; else HREADYM if data_act; else 1.
- HRESPS = data_act ? HRESPM : 0. The two-cycle ERROR passes through unchanged; the first cycle has HRESPM=1 and HREADYM=0.
- Latency: a granted, ready live transfer passes combinationally (0 cycles). An ungranted transfer waits one cycle minimum, then is issued from the hold registers.
- One-deep hold suffices because HREADYOUTS=0 while pend=1, so the master cannot issue. Assertion: live_valid & pend never occurs.
- Burst continuation: SEQ beats re-arbitrate like NONSEQ. The arbiter's burst-hold keeps the grant, so normal bursts never capture after the first beat.
- Reset mid-operation: pend and data_act are cleared unconditionally, and any held transfer is discarded.
- HSELS low with pend=1: the held transfer is still issued, because it was already accepted from the master.

Test Plan:
- Reset → HREADYOUTS=1, HRESPS=0, trans_req=0, HTRANSI=00, all for one cycle after HRESET falls with HSELS=0.
- NONSEQ write to 0x2000_0010 with addr_granted=1, HREADYM=1 → same-cycle pass-through with HADDRI=0x2000_0010 and HTRANSI=10, no capture. Next cycle data_act=1 and HREADYOUTS=HREADYM.
- NONSEQ read to 0x2000_0040 with addr_granted=0 for 3 cycles → pend=1, HREADYOUTS=0, trans_req=1, HADDRI held at 0x2000_0040 while HADDRS changes to 0xDEAD_BEEF. addr_granted=1 in cycle 4 → pend=0 next cycle, then data phase completes.
- INCR4 burst, HREADYM low for 2 cycles on beat 2 → HREADYOUTS follows HREADYM, all 4 beats accepted, no capture, and data_act drops one cycle after the last beat completes.
- Target ERROR (HRESPM=1 with HREADYM=0, then HRESPM=1 with HREADYM=1) → HRESPS=1 on both cycles and HREADYOUTS=0 then 1.
- HRESET asserted with pend=1 and data_act=1 → next cycle pend=0, data_act=0, HREADYOUTS=1, trans_req=0.
